// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU step controller: mode encodings and
// debounce sizing helpers.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_STEP = 2'b01,
    MODE_HALT = 2'b10
  } mode_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 270000;

  // Counter width for a debounce window; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces one raw board button, producing a stable
// pressed level and a one-cycle pulse on each accepted press.
module button_debouncer
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          IDLE_RAW = ACTIVE_LOW;

  logic          sync1;
  logic          sync2;
  logic          synced;
  logic [CW-1:0] count;

  // Normalized so that 1 always means pressed.
  assign synced = sync2 ^ IDLE_RAW;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sync1 <= IDLE_RAW;
      sync2 <= IDLE_RAW;
      level <= 1'b0;
      count <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (synced != level) begin
        if (count == LAST) begin
          level <= synced;
          count <= '0;
          press <= synced;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_step_controller.sv
// Turns slow divider ticks into single-cycle CPU enable strobes and adds
// run / single-step / halt control driven by two debounced buttons.
module cpu_step_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        tick_in,
  input  logic        btn_mode_in,
  input  logic        btn_step_in,
  input  logic        halt_in,
  output logic        cpu_en,
  output logic [1:0]  mode,
  output logic [31:0] cpu_cycles
);

  mode_t state;
  logic  tick_q;
  logic  rise;
  logic  mode_press;
  logic  step_press;
  logic  unused_mode_level;
  logic  unused_step_level;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (BTN_ACTIVE_LOW)
  ) u_mode_btn (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .btn_raw  (btn_mode_in),
    .level    (unused_mode_level),
    .press    (mode_press)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (BTN_ACTIVE_LOW)
  ) u_step_btn (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .btn_raw  (btn_step_in),
    .level    (unused_step_level),
    .press    (step_press)
  );

  assign rise = tick_in & ~tick_q;
  assign mode = state;

  // cpu_en is decided from the mode held before this edge's transition.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state      <= MODE_RUN;
      cpu_en     <= 1'b0;
      cpu_cycles <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_q     <= tick_in;
      cpu_cycles <= cpu_cycles + 32'(cpu_en);
      if (halt_in) begin
        state  <= MODE_HALT;
        cpu_en <= 1'b0;
      end else begin
        case (state)
          MODE_RUN: begin
            cpu_en <= rise;
            if (mode_press) state <= MODE_STEP;
          end
          MODE_STEP: begin
            cpu_en <= step_press;
            if (mode_press) state <= MODE_RUN;
          end
          MODE_HALT: begin
            cpu_en <= 1'b0;
            if (mode_press) state <= MODE_STEP;
          end
          default: begin
            state  <= MODE_RUN;
            cpu_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
